fp_accumulator: RTL
===================

# fp_accumulator

Sequential IEEE-754 single-precision accumulator that sums a stream of floating-point values, one vector at a time, and emits the total with an element count. It sits directly downstream of `fp_mul` / the exponent stage in the softmax datapath and produces the softmax denominator (Σ e^x) consumed by the divider. It accepts one operand every 4 cycles through a valid/ready handshake and presents the result through a second valid/ready handshake.

## Interface
- `DATA_WIDTH`, 32, operand width; only 32 is supported.
- `CNT_WIDTH`, 8, width of the element counter.

- `clk` in 1 — single clock, rising edge.
- `rst` in 1 — reset, asynchronous, active-high.
- `in_valid` in 1 — `in_data` / `in_last` valid.
- `in_ready` out 1 — accumulator can take an operand.
- `in_data` in DATA_WIDTH — IEEE-754 single operand.
- `in_last` in 1 — operand is the final element of the vector.
- `out_valid` out 1 — `out_data` / `out_count` valid.
- `out_ready` in 1 — consumer takes the result.
- `out_data` out DATA_WIDTH — vector sum.
- `out_count` out CNT_WIDTH — number of elements summed; saturates at all-ones.
- `busy` out 1 — high in any state other than ACCEPT.

## Operation
- States: ACCEPT, ALIGN, ADD, NORM, OUT.
- ACCEPT:
  - `in_ready` = 1.
  - On `in_valid && in_ready`, latch the operand and `in_last`, increment the count (saturating), then go to ALIGN.
- ALIGN:
  - Unpack the accumulator and the operand, restoring the hidden bit.
  - Swap so the larger magnitude is first.
  - Right-shift the smaller mantissa by the exponent difference, keeping guard, round and sticky bits. A shift of 27 or more yields sticky only.
- ADD: add the mantissas if the signs match, else subtract the smaller from the larger. Result is 25 bits + GRS.
- NORM:
  - Leading-zero count and shift, or a 1-bit right shift on carry-out.
  - Adjust the exponent.
  - Round to nearest, ties to even; handle mantissa overflow from rounding.
  - Write the accumulator.
  - Next state is OUT if the latched `in_last` = 1, else ACCEPT.
- OUT:
  - `out_valid` = 1; `out_data` = accumulator; `out_count` = count.
  - On `out_ready`, clear the accumulator to +0 and the count to 0, then go to ACCEPT.
- Arithmetic rules:
  - Input denormals are flushed to zero of the same sign.
  - A result exponent ≤ 0 is flushed to +0.
  - Exact cancellation gives +0.
  - A +0 operand leaves the accumulator unchanged, but is still counted.
- `in_last` with a single element: output = that element (after denormal flush).
- Reset mid-operation: the state returns to ACCEPT, the accumulator and count clear, and any in-flight operand is discarded.

## Timing
- Reset values:
  - `in_ready` = 1.
  - `out_valid` = 0, `out_data` = 0, `out_count` = 0.
  - `busy` = 0.
  - State = ACCEPT, accumulator = +0.
- Operand handshake at edge E: ALIGN at E+1, ADD at E+2, NORM at E+3. The accumulator is written and the state leaves NORM at edge E+3.
- `in_ready` reasserts 3 cycles after a handshake, giving a throughput of 1 operand per 4 cycles.
- With `in_valid` held high, an N-element vector has `out_valid` high starting 4N−1 cycles after the first handshake edge.
- `out_valid`, `out_data` and `out_count` stay stable until `out_ready` is sampled high. `in_ready` = 0 throughout OUT.
- Result handshake at edge F: `in_ready` = 1 in the cycle after F, and a new vector may start there.
- `in_data` is sampled only on the handshake edge and may change freely afterwards.

## Configuration
- `FP_ACC_SPECIALS_EN` defined — full IEEE special handling:
  - Inf + finite = Inf.
  - Inf + (−Inf) = NaN 0x7FC00000.
  - Any NaN input gives 0x7FC00000.
  - Overflow gives ±Inf (0x7F800000 / 0xFF800000).
  - Once the accumulator holds Inf or NaN, it holds that value until it is cleared.
- Undefined:
  - An input with exponent 255 is replaced by the signed maximum finite value (0x7F7FFFFF / 0xFF7FFFFF).
  - Overflow saturates to the signed maximum finite value.
  - NaN and Inf are never produced.

## Test plan
- Sum of 2 → 5.0, consumer always ready:
  - Stimulus: 0x40000000 (2.0), then 0x40400000 (3.0) with `in_last`.
  - Response: `out_data` = 0x40A00000 (5.0), `out_count` = 2, `out_valid` rises 7 cycles after the first handshake.
- Sum of 3 → 6.0:
  - Stimulus: 1.0, 2.0, 3.0 (0x3F800000, 0x40000000, 0x40400000), last on the third.
  - Response: 0x40C00000, count 3, `in_ready` low exactly 3 cycles after each accept.
- Cancellation and rounding:
  - 3.0 + (−3.0) (0xC0400000) → 0x00000000.
  - 1.0 + 0x33800000 (2^-24, tie) → 0x3F800000.
  - 1.0 + 0x33800001 → 0x3F800001.
- Backpressure:
  - Stimulus: hold `out_ready` = 0 for 5 cycles after `out_valid` rises.
  - Response: `out_data` / `out_count` constant and `in_ready` = 0 during the stall. After `out_ready`, the next vector {2.0 last} → 0x40000000, count 1, with no carry-over.
- Reset mid-operation:
  - Stimulus: assert `rst` while in ADD with 2.0 already accumulated.
  - Response: outputs go to their reset values immediately. A following vector {3.0 last} → 0x40400000.
- Specials:
  - 0x7F800000 + 1.0 → 0x7F800000 with `FP_ACC_SPECIALS_EN`, 0x7F7FFFFF without.
  - 0x7F7FFFFF + 0x7F7FFFFF → 0x7F800000 with, 0x7F7FFFFF without.

Source files
------------

// File: rtl/fp_accumulator.sv
// rtl/fp_accumulator.sv - sequential IEEE-754 single-precision vector accumulator (softmax denominator)
// FP_ACC_SPECIALS_EN selects full Inf/NaN handling; otherwise overflow saturates to max finite.
module fp_accumulator #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [CNT_WIDTH-1:0]  out_count,
  output logic                  busy
);

  typedef enum logic [2:0] {S_ACCEPT, S_ALIGN, S_ADD, S_NORM, S_OUT} state_t;
  state_t state, state_nx;

  logic [DATA_WIDTH-1:0] acc, op, op_in;
  logic                  last_q;
  logic [CNT_WIDTH-1:0]  count;

  logic [26:0] big_q, small_q;
  logic [7:0]  big_e_q, sum_e_q;
  logic        big_s_q, sub_q, sum_s_q;
  logic [27:0] sum_q;
  logic        spec1_q, spec2_q;
  logic [31:0] spec1_v, spec2_v;

  logic [7:0]  a_e, b_e, hi_e, lo_e, diff;
  logic [23:0] a_m, b_m, hi_m, lo_m;
  logic        a_s, b_s, hi_s, lost;
  logic [26:0] lo_ext, lo_sh;
  logic        spec_hit;
  logic [31:0] spec_val;
  logic [30:0] ovf_mag;

  function automatic logic [4:0] lzc27(input logic [26:0] v);
    lzc27 = 5'd27;
    for (int i = 0; i < 27; i++)
      if (v[i]) lzc27 = 5'(26 - i);
  endfunction

`ifdef FP_ACC_SPECIALS_EN
  logic a_nan, b_nan, a_inf, b_inf;
  always_comb begin
    a_nan    = (acc[30:23] == 8'hFF) && (acc[22:0] != 23'd0);
    b_nan    = (op[30:23] == 8'hFF) && (op[22:0] != 23'd0);
    a_inf    = (acc[30:23] == 8'hFF) && (acc[22:0] == 23'd0);
    b_inf    = (op[30:23] == 8'hFF) && (op[22:0] == 23'd0);
    spec_hit = (acc[30:23] == 8'hFF) || (op[30:23] == 8'hFF);
    if (a_nan || b_nan || (a_inf && b_inf && (acc[31] != op[31])))
      spec_val = 32'h7FC00000;
    else if (a_inf)
      spec_val = acc;
    else
      spec_val = op;
  end
  assign ovf_mag = 31'h7F800000;
  assign op_in   = (in_data[30:23] == 8'd0) ? {in_data[31], 31'd0} : in_data;
`else
  assign spec_hit = 1'b0;
  assign spec_val = 32'd0;
  assign ovf_mag  = 31'h7F7FFFFF;
  // Exponent-255 inputs are clamped on entry so Inf/NaN never reach the datapath.
  always_comb begin
    if (in_data[30:23] == 8'd0)
      op_in = {in_data[31], 31'd0};
    else if (in_data[30:23] == 8'hFF)
      op_in = {in_data[31], 31'h7F7FFFFF};
    else
      op_in = in_data;
  end
`endif

  // Align: order by magnitude, shift the smaller operand keeping G/R/S.
  always_comb begin
    a_e = acc[30:23];
    b_e = op[30:23];
    a_s = acc[31];
    b_s = op[31];
    a_m = (a_e == 8'd0) ? 24'd0 : {1'b1, acc[22:0]};
    b_m = (b_e == 8'd0) ? 24'd0 : {1'b1, op[22:0]};
    if ({a_e, a_m} >= {b_e, b_m}) begin
      hi_e = a_e; hi_m = a_m; hi_s = a_s; lo_e = b_e; lo_m = b_m;
    end else begin
      hi_e = b_e; hi_m = b_m; hi_s = b_s; lo_e = a_e; lo_m = a_m;
    end
    diff   = hi_e - lo_e;
    lo_ext = {lo_m, 3'b000};
    lost   = |(lo_ext & ((27'd1 << diff) - 27'd1));
    if (diff >= 8'd27)
      lo_sh = {26'd0, |lo_m};
    else
      lo_sh = (lo_ext >> diff) | {26'd0, lost};
  end

  logic [4:0]        lz;
  logic [26:0]       nm;
  logic signed [9:0] ne_pre, ne;
  logic              rup;
  logic [24:0]       m25;
  logic [22:0]       frac;
  logic [31:0]       norm_res;

  always_comb begin
    lz = lzc27(sum_q[26:0]);
    if (sum_q[27]) begin
      nm     = {sum_q[27:2], sum_q[1] | sum_q[0]};
      ne_pre = $signed({2'b00, sum_e_q}) + 10'sd1;
    end else begin
      nm     = sum_q[26:0] << lz;
      ne_pre = $signed({2'b00, sum_e_q}) - $signed({5'd0, lz});
    end
    rup  = nm[2] & (nm[1] | nm[0] | nm[3]);
    m25  = {1'b0, nm[26:3]} + {24'd0, rup};
    ne   = ne_pre + (m25[24] ? 10'sd1 : 10'sd0);
    frac = m25[24] ? m25[23:1] : m25[22:0];
    if (spec2_q)
      norm_res = spec2_v;
    else if (sum_q == 28'd0 || ne <= 10'sd0)
      norm_res = 32'd0;
    else if (ne >= 10'sd255)
      norm_res = {sum_s_q, ovf_mag};
    else
      norm_res = {sum_s_q, ne[7:0], frac};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_ACCEPT;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_ACCEPT: if (in_valid) state_nx = S_ALIGN;
      S_ALIGN:  state_nx = S_ADD;
      S_ADD:    state_nx = S_NORM;
      S_NORM:   state_nx = last_q ? S_OUT : S_ACCEPT;
      S_OUT:    if (out_ready) state_nx = S_ACCEPT;
      default:  state_nx = S_ACCEPT;
    endcase
  end

  always_comb begin
    in_ready  = (state == S_ACCEPT);
    busy      = (state != S_ACCEPT);
    out_valid = (state == S_OUT);
    out_data  = out_valid ? acc : '0;
    out_count = out_valid ? count : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0; op <= '0; last_q <= 1'b0; count <= '0;
      big_q <= '0; small_q <= '0; big_e_q <= '0; big_s_q <= 1'b0; sub_q <= 1'b0;
      sum_q <= '0; sum_e_q <= '0; sum_s_q <= 1'b0;
      spec1_q <= 1'b0; spec2_q <= 1'b0; spec1_v <= '0; spec2_v <= '0;
    end else begin
      case (state)
        S_ACCEPT: if (in_valid) begin
          op     <= op_in;
          last_q <= in_last;
          if (count != '1) count <= count + 1'b1;
        end
        S_ALIGN: begin
          big_q   <= {hi_m, 3'b000};
          small_q <= lo_sh;
          big_e_q <= hi_e;
          big_s_q <= hi_s;
          sub_q   <= a_s ^ b_s;
          spec1_q <= spec_hit;
          spec1_v <= spec_val;
        end
        S_ADD: begin
          sum_q   <= sub_q ? ({1'b0, big_q} - {1'b0, small_q}) : ({1'b0, big_q} + {1'b0, small_q});
          sum_e_q <= big_e_q;
          sum_s_q <= big_s_q;
          spec2_q <= spec1_q;
          spec2_v <= spec1_v;
        end
        S_NORM: acc <= norm_res;
        S_OUT: if (out_ready) begin
          acc   <= '0;
          count <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule
